// File: rtl/alu_pkg.sv
// Shared widths, arbiter FSM states and opcode names for the shared-ALU datapath slice.
package alu_pkg;

    localparam int unsigned ALU_W = 16;
    localparam int unsigned SEL_W = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    localparam logic [SEL_W-1:0] OP_PASS = 4'b0000;
    localparam logic [SEL_W-1:0] OP_XOR  = 4'b0101;
    localparam logic [SEL_W-1:0] OP_SUB  = 4'b0110;
    localparam logic [SEL_W-1:0] OP_ADD  = 4'b1001;
    localparam logic [SEL_W-1:0] OP_INC  = 4'b1111;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: searches from last+1 upward, wrapping modulo NREQ.
module rr_arbiter #(
    parameter int unsigned NREQ = 2,
    parameter int unsigned IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  last,
    output logic [NREQ-1:0] grant,
    output logic [IDW-1:0]  grant_id
);

    logic [IDW-1:0] cand;
    logic           found;

    always_comb begin
        grant    = '0;
        grant_id = '0;
        cand     = '0;
        found    = 1'b0;
        // off = NREQ lands back on last itself, so it has the lowest priority
        for (int unsigned off = 1; off <= NREQ; off++) begin
            cand = IDW'((32'(last) + off) % NREQ);
            if (!found && req[cand]) begin
                found       = 1'b1;
                grant[cand] = 1'b1;
                grant_id    = cand;
            end
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one combinational ALU between NREQ requesters, one request in flight at a time,
// with the result held in a response register under a valid/ready handshake.
module alu_arbiter
    import alu_pkg::*;
#(
    parameter int unsigned NREQ = 2,
    parameter int unsigned IDW  = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*ALU_W-1:0] req_a,
    input  logic [NREQ*ALU_W-1:0] req_b,
    input  logic [NREQ*SEL_W-1:0] req_sel,
    input  logic [NREQ-1:0]       req_cin,
    output logic [ALU_W-1:0]      alu_a,
    output logic [ALU_W-1:0]      alu_b,
    output logic [SEL_W-1:0]      alu_sel,
    output logic                  alu_cin,
    input  logic [ALU_W-1:0]      alu_out,
    input  logic                  alu_cout,
    input  logic                  alu_cmp,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [IDW-1:0]        rsp_id,
    output logic [ALU_W-1:0]      rsp_data,
    output logic                  rsp_cout,
    output logic                  rsp_cmp
);

    arb_state_t       state_q;
    logic [ALU_W-1:0] op_a_q;
    logic [ALU_W-1:0] op_b_q;
    logic [SEL_W-1:0] op_sel_q;
    logic             op_cin_q;
    logic [IDW-1:0]   cur_id_q;
    logic [IDW-1:0]   last_grant_q;
    logic             rsp_valid_q;
    logic [IDW-1:0]   rsp_id_q;
    logic [ALU_W-1:0] rsp_data_q;
    logic             rsp_cout_q;
    logic             rsp_cmp_q;

    logic [NREQ-1:0]  grant;
    logic [IDW-1:0]   grant_id;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_rr_arbiter (
        .req      (req_valid),
        .last     (last_grant_q),
        .grant    (grant),
        .grant_id (grant_id)
    );

    assign req_ready = (state_q == IDLE) ? grant : '0;

    // The ALU is combinational, so it may see the operand register in every state
    assign alu_a   = op_a_q;
    assign alu_b   = op_b_q;
    assign alu_sel = op_sel_q;
    assign alu_cin = op_cin_q;

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = rsp_id_q;
    assign rsp_data  = rsp_data_q;
    assign rsp_cout  = rsp_cout_q;
    assign rsp_cmp   = rsp_cmp_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            op_a_q       <= '0;
            op_b_q       <= '0;
            op_sel_q     <= '0;
            op_cin_q     <= 1'b0;
            cur_id_q     <= '0;
            last_grant_q <= IDW'(NREQ - 1);
            rsp_valid_q  <= 1'b0;
            rsp_id_q     <= '0;
            rsp_data_q   <= '0;
            rsp_cout_q   <= 1'b0;
            rsp_cmp_q    <= 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (|req_valid) begin
                        op_a_q       <= req_a[ALU_W*grant_id +: ALU_W];
                        op_b_q       <= req_b[ALU_W*grant_id +: ALU_W];
                        op_sel_q     <= req_sel[SEL_W*grant_id +: SEL_W];
                        op_cin_q     <= req_cin[grant_id];
                        cur_id_q     <= grant_id;
                        last_grant_q <= grant_id;
                        state_q      <= EXEC;
                    end
                end
                EXEC: begin
                    rsp_data_q  <= alu_out;
                    rsp_cout_q  <= alu_cout;
                    rsp_cmp_q   <= alu_cmp;
                    rsp_id_q    <= cur_id_q;
                    rsp_valid_q <= 1'b1;
                    state_q     <= RESP;
                end
                RESP: begin
                    if (rsp_ready) begin
                        rsp_valid_q <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/alu_arbiter.md
# alu_arbiter

Shares one 16-bit combinational `arithmetic` ALU between `NREQ` requesters. Round-robin arbitration selects one request at a time. The arbiter latches that request's operands, drives the ALU for one cycle and captures the result into a response register. The response is held under a valid/ready handshake. The block sits between the instruction-issue front ends and the single ALU instance of the datapath.

## Interface
Parameters:
- `NREQ`, default 2: number of requesters; legal range 2..8.
- `IDW`, default `$clog2(NREQ)`: width of the requester ID.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `req_valid` in NREQ: bit i means requester i holds a request.
- `req_ready` out NREQ: one-hot; bit i means requester i's request is accepted this cycle.
- `req_a` in NREQ*16: packed operand A; slice i is `[16*i+15:16*i]`.
- `req_b` in NREQ*16: packed operand B.
- `req_sel` in NREQ*4: packed ALU operation select.
- `req_cin` in NREQ: carry-in per requester.
- `alu_a` out 16: operand A to the ALU.
- `alu_b` out 16: operand B to the ALU.
- `alu_sel` out 4: operation select to the ALU.
- `alu_cin` out 1: carry-in to the ALU.
- `alu_out` in 16: ALU result.
- `alu_cout` in 1: ALU carry-out.
- `alu_cmp` in 1: ALU equality compare.
- `rsp_valid` out 1: a response is held in the response register.
- `rsp_ready` in 1: the consumer accepts the response.
- `rsp_id` out IDW: index of the requester that owns the response.
- `rsp_data` out 16: captured result.
- `rsp_cout` out 1: captured carry-out.
- `rsp_cmp` out 1: captured compare.

## Operation
- FSM states:
  - IDLE → EXEC when any `req_valid` bit is set.
  - EXEC → RESP always, after one cycle.
  - RESP → IDLE when `rsp_ready` is high.
- Grant:
  - Combinational round-robin over `req_valid`.
  - Search starts at `last_grant + 1` and wraps modulo NREQ.
  - `req_ready[i] = (state==IDLE) && grant[i]`. `req_ready` depends on `req_valid`; requesters must not make `req_valid` depend on `req_ready`.
- Handshake:
  - A request transfers when `req_valid[i] && req_ready[i]`.
  - On transfer: latch a, b, sel, cin into the operand register, latch i into `cur_id`, and update `last_grant` to i.
  - A requester keeps its payload stable while valid and not yet ready.
- EXEC:
  - `alu_*` outputs come straight from the operand register.
  - At the end of EXEC: capture `alu_out`, `alu_cout` and `alu_cmp` into the response register, and copy `cur_id` to `rsp_id`.
- RESP:
  - `rsp_valid` is high; all response fields are held stable until `rsp_ready`.
  - `req_ready` is all zeros.
- Outside EXEC, `alu_*` still mirror the operand register. The ALU is combinational, so this is harmless and avoids extra muxing.
- `sel` and `cin` pass through unmodified. The arbiter does not decode operations.
- Only one request is in flight. No request is accepted in EXEC or RESP.

## Timing
- Reset values:
  - state IDLE.
  - `req_ready` = 0, because there is no grant without valid.
  - `rsp_valid` = 0; `rsp_id`, `rsp_data`, `rsp_cout`, `rsp_cmp` = 0.
  - operand register 0, so `alu_a`, `alu_b`, `alu_sel`, `alu_cin` = 0.
  - `last_grant` = NREQ-1, so requester 0 wins first.
- Latency: handshake in cycle N; EXEC in cycle N+1; `rsp_valid` high in cycle N+2.
- Throughput with `rsp_ready` held high: one request per 3 cycles.
  - RESP→IDLE takes the cycle in which `rsp_ready` is seen.
  - The next grant comes in the following IDLE cycle.
- Simultaneous requests: only the round-robin winner gets ready. All others wait with `req_ready` low.
- Fairness: with all requesters continuously valid, grants cycle 0,1,…,NREQ-1,0.
- A `req_valid` that drops while not granted is legal. No state changes.
- Reset asserted in any state: everything returns to reset values immediately (asynchronously). An in-flight request is discarded and no response is produced.
- `rsp_ready` high outside RESP is ignored.

## Structure
- Shared package `alu_pkg`:
  - `ALU_W` = 16 and `SEL_W` = 4.
  - `arb_state_t` enum {IDLE, EXEC, RESP}.
  - Named opcode localparams, e.g. `OP_ADD` = 4'b1001, `OP_INC` = 4'b1111, `OP_PASS` = 4'b0000.
- Sub-module `rr_arbiter`:
  - Parameter `NREQ`.
  - Inputs `req[NREQ]`, `last[IDW]`.
  - Outputs one-hot `grant` and encoded `grant_id`.
  - Purely combinational.
- Top level holds the FSM, operand register, response register and `last_grant`.

## Test plan
- Single ADD: requester 0, sel 4'b1001, a=0x0003, b=0x0004 → after 2 cycles `rsp_valid`=1, `rsp_data`=0x0007, `rsp_cout`=0, `rsp_id`=0.
- Carry and compare: requester 1, sel 4'b1111, a=0xFFFF → `rsp_data`=0x0000, `rsp_cout`=1. Then sel 4'b0000, a=b=0x1234 → `rsp_data`=0x1234, `rsp_cmp`=1.
- Fairness: both requesters held valid for 12 cycles with `rsp_ready`=1 → grant order 0,1,0,1, one acceptance every 3 cycles.
- Backpressure: `rsp_ready` low for 5 cycles in RESP → response fields stable, `req_ready`=0 throughout, accept on the first high cycle.
- Reset mid-operation: assert `rst_n`=0 during EXEC → `rsp_valid` stays 0, state IDLE. After release, requester 0 wins over requester 1 when both are valid.
